// File: rtl/lc3b_types.sv
// lc3b_types -- shared LC-3b datapath types.
//   lc3b_word       : 16-bit machine word
//   lc3b_mult_state : control states of the iterative multiplier (mult_unit)
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lc3b_mult_state;

    // Highest value of the iteration counter; the iteration that sees it is the
    // 16th and therefore the last one any 16-bit multiplier can need.
    localparam logic [3:0] MULT_LAST_COUNT = 4'd15;

endpackage

// File: rtl/mult_unit.sv
// mult_unit -- iterative shift/add multiplier for the EX stage.
// Returns the low 16 bits of a*b, which is the same for signed and unsigned
// operands. One partial product is added per BUSY cycle; the operation ends
// early once no set multiplier bits remain.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   start  in   request a multiply (accepted only in IDLE)
//   flush  in   pipeline squash; aborts any operation in progress
//   a      in   multiplicand
//   b      in   multiplier
//   f      out  low 16 bits of a*b; valid with done, held until next start
//   busy   out  high while BUSY or DONE (combinational from state)
//   done   out  one-cycle pulse when f is valid
module mult_unit
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     start,
    input  logic     flush,
    input  lc3b_word a,
    input  lc3b_word b,
    output lc3b_word f,
    output logic     busy,
    output logic     done
);

    lc3b_mult_state state, next_state;

    lc3b_word   mcand;
    lc3b_word   mplier;
    lc3b_word   acc;
    logic [3:0] count;

    lc3b_word   acc_next;
    lc3b_word   mplier_shift;

    // ------------------------------------------------------------------
    // Next-state and datapath arithmetic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        next_state   = state;
        acc_next     = acc;
        mplier_shift = mplier >> 1;

        if (mplier[0])
            acc_next = acc + mcand;

        case (state)
            IDLE: begin
                // flush wins over a simultaneous start
                if (start && !flush)
                    next_state = BUSY;
            end
            BUSY: begin
                if (flush)
                    next_state = IDLE;
                else if (mplier_shift == '0 || count == MULT_LAST_COUNT)
                    next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            f      <= '0;
            done   <= 1'b0;
            acc    <= '0;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            // done is high exactly for the cycle spent in DONE; a flush sends
            // next_state to IDLE, which drops it.
            done <= (next_state == DONE);

            case (state)
                IDLE: begin
                    if (next_state == BUSY) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                BUSY: begin
                    if (!flush) begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier_shift;
                        count  <= count + 4'd1;
                        // Publish the final sum as we enter DONE so f is
                        // registered and valid alongside done.
                        if (next_state == DONE)
                            f <= acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit -- self-checking bench for mult_unit.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mult_unit;
    import lc3b_types::*;

    logic     clk = 1'b0;
    logic     reset;
    logic     start;
    logic     flush;
    lc3b_word a;
    lc3b_word b;
    lc3b_word f;
    logic     busy;
    logic     done;

    int checks = 0;
    int errors = 0;

    mult_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .flush (flush),
        .a     (a),
        .b     (b),
        .f     (f),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    name;
        lc3b_word a;
        lc3b_word b;
        lc3b_word exp_f;
        int       exp_cycles;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue a one-cycle start and wait for done. Returns the number of BUSY
    // cycles observed (-1 on timeout). Leaves the bench at the DONE negedge.
    task automatic run_op(input lc3b_word va, input lc3b_word vb, output int cycles);
        int n;
        bit seen;
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            n++;
            @(negedge clk);
        end
        cycles = seen ? n : -1;
    endtask

    initial begin
        int cyc;
        int pulses;
        lc3b_word prior;

        vecs[0] = '{"3x5",       16'h0003, 16'h0005, 16'h000F, 3};
        vecs[1] = '{"1234x0",    16'h1234, 16'h0000, 16'h0000, 1};
        vecs[2] = '{"ffffx8000", 16'hFFFF, 16'h8000, 16'h8000, 16};
        vecs[3] = '{"m2xm3",     16'hFFFE, 16'hFFFD, 16'h0006, 16};
        vecs[4] = '{"7x9",       16'h0007, 16'h0009, 16'h003F, 4};
        vecs[5] = '{"ffxff",     16'h00FF, 16'h00FF, 16'hFE01, 8};
        vecs[6] = '{"1x1",       16'h0001, 16'h0001, 16'h0001, 1};
        vecs[7] = '{"abcdx2",    16'hABCD, 16'h0002, 16'h579A, 2};
        vecs[8] = '{"100x100",   16'h0100, 16'h0100, 16'h0000, 9};
        vecs[9] = '{"m1xm1",     16'hFFFF, 16'hFFFF, 16'h0001, 16};

        reset = 1'b1; start = 1'b0; flush = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_f", f, 16'h0000);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        reset = 1'b0;

        // Table-driven operations
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, cyc);
            check({vecs[i].name, "_cycles"}, cyc, vecs[i].exp_cycles);
            check({vecs[i].name, "_f"}, f, vecs[i].exp_f);
            check({vecs[i].name, "_busy_in_done"}, busy, 1'b1);
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, done, 1'b0);
            check({vecs[i].name, "_idle"}, busy, 1'b0);
            check({vecs[i].name, "_f_hold"}, f, vecs[i].exp_f);
        end

        // start and flush together in IDLE: flush wins
        @(negedge clk);
        a = 16'h0003; b = 16'h0005; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("start_flush_idle", busy, 1'b0);
        start = 1'b0; flush = 1'b0;

        // start held high: one result, restart only after DONE
        a = 16'h0003; b = 16'h0005; start = 1'b1;
        pulses = 0;
        cyc = 0;
        @(negedge clk);
        check("held_busy", busy, 1'b1);
        for (int i = 0; i < 40 && !done; i++) begin
            cyc++;
            @(negedge clk);
        end
        check("held_cycles", cyc, 3);
        check("held_done", done, 1'b1);
        check("held_f", f, 16'h000F);
        @(negedge clk);
        check("held_idle_after_done", busy, 1'b0);
        check("held_no_second_done", done, 1'b0);
        @(negedge clk);
        check("held_restart", busy, 1'b1);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("held_second_result_pulses", pulses, 1);
        check("held_second_f", f, 16'h000F);

        // flush in the third BUSY cycle of 0x00FF*0x00FF
        prior = f;
        a = 16'h00FF; b = 16'h00FF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;                    // BUSY cycle 1
        @(negedge clk);                  // BUSY cycle 2
        @(negedge clk);                  // BUSY cycle 3
        check("flush_pre_busy", busy, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", busy, 1'b0);
        check("flush_done", done, 1'b0);
        check("flush_f_kept", f, prior);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        check("flush_no_activity", pulses, 0);
        check("flush_f_still", f, prior);

        // reset mid-BUSY, then a clean 7*9
        a = 16'h1234; b = 16'h00FF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy_clear", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_f", f, 16'h0000);
        run_op(16'h0007, 16'h0009, cyc);
        check("post_rst_cycles", cyc, 4);
        check("post_rst_f", f, 16'h003F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
